// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//
// Sequential stimulus/capture stage that sits in front of a 4-input
// combinational function block. A start request walks abcd through all
// 16 input combinations. Each vector is held for SETTLE+1 cycles, and
// f_in is captured on the last cycle of each hold. The 16 captured bits
// form table_out, which is compared against EXPECTED. The result is
// reported through pass, mismatch_count and a one-cycle done pulse.
//
// Parameters:
//   SETTLE    hold cycles per vector before f_in is sampled (1..15)
//   EXPECTED  expected truth table; bit i is f for abcd = i
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           scan request, only looked at while idle
//   abcd            vector driven to the function block (bit3 = a, bit0 = d)
//   f_in            function block output, combinational from abcd
//   busy            high while a scan is in progress
//   done            one-cycle pulse when the scan ends
//   table_out       captured truth table, bit i for abcd = i
//   pass            table_out matched EXPECTED (valid from done)
//   mismatch_count  number of bits that differed from EXPECTED
//
// Optional feature:
//   TTS_ABORT_EN  when defined, the first mismatching vector ends the scan
//                 early. mismatch_count is then 1, and table_out keeps only
//                 the bits captured up to that point.

module truth_table_scanner #(
    parameter int unsigned  SETTLE   = 1,
    parameter logic [15:0]  EXPECTED = 16'h7FB8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  abcd,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        pass,
    output logic [4:0]  mismatch_count
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        FIN
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  settle_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [15:0] table_q;
    logic [4:0]  mismatch_q;

    logic        miss_d;
    logic [4:0]  mismatch_d;
    logic        last_d;

    // Comparison of the current sample against the expected bit, and the
    // decision whether this SAMPLE cycle finishes the scan.
    always_comb begin
        miss_d     = (f_in != EXPECTED[idx_q]);
        mismatch_d = mismatch_q + {4'd0, miss_d};
`ifdef TTS_ABORT_EN
        last_d     = (idx_q == 4'd15) || miss_d;
`else
        last_d     = (idx_q == 4'd15);
`endif
    end

    // Scan sequencer. The vector index doubles as the abcd register, so
    // abcd holds its last value in IDLE and FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            settle_q   <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            table_q    <= 16'd0;
            mismatch_q <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= HOLD;
                        idx_q      <= 4'd0;
                        settle_q   <= 4'd0;
                        table_q    <= 16'd0;
                        mismatch_q <= 5'd0;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                HOLD: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= 4'd0;
                        state_q  <= SAMPLE;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                SAMPLE: begin
                    table_q[idx_q] <= f_in;
                    mismatch_q     <= mismatch_d;
                    if (last_d) begin
                        // The pass verdict includes the bit captured here.
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (mismatch_d == 5'd0);
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= HOLD;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign abcd           = idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign table_out      = table_q;
    assign mismatch_count = mismatch_q;

endmodule
